mk_chan_accum: RTL



---
 rtl/mk_chan_accum_pkg.sv | 11 +
 rtl/mk_chan_accum_lane.sv | 34 +++
 rtl/mk_chan_accum.sv | 95 +++++++++
 3 files changed

// File: rtl/mk_chan_accum_pkg.sv
// mk_chan_accum_pkg: shared state encoding, default sizes and index-width helper for mk_chan_accum.
package mk_chan_accum_pkg;
  localparam int DEF_W = 5;
  localparam int DEF_NCH = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_IDX_W = idx_w(DEF_NCH);
endpackage

// File: rtl/mk_chan_accum_lane.sv
// mk_chan_accum_lane: one channel register with valid flag, result adder and check XOR.
module mk_chan_accum_lane
  import mk_chan_accum_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         en_check,
  output logic [W-1:0] result,
  output logic [W-1:0] check,
  output logic         rdy
);
  logic [W-1:0] value;
  logic         valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      value <= wr_data;
      valid <= 1'b1;
    end else if (en_check && valid) begin
      valid <= 1'b0;
    end
  end
  assign result = valid ? value + c : '0;
  assign check  = valid ? value ^ d : '0;
  assign rdy    = valid;
endmodule

// File: rtl/mk_chan_accum.sv
// mk_chan_accum: start/run/drain accumulator filling NCH channels with a+(k+1)*b.
// Optional saturating mismatch counter enabled by MK_CHAN_ACCUM_MISMATCH_CNT_EN.
module mk_chan_accum
  import mk_chan_accum_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int NCH = DEF_NCH
`ifdef MK_CHAN_ACCUM_MISMATCH_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [W-1:0]     start_a,
  input  logic [W-1:0]     start_b,
  input  logic             EN_start,
  output logic             RDY_start,
  input  logic [NCH*W-1:0] variable_result_c,
  output logic [NCH*W-1:0] variable_result,
  output logic [NCH-1:0]   RDY_variable_result,
  input  logic [NCH*W-1:0] variable_check_d,
  input  logic [NCH-1:0]   EN_variable_check,
  output logic [NCH*W-1:0] variable_check,
  output logic [NCH-1:0]   RDY_variable_check
`ifdef MK_CHAN_ACCUM_MISMATCH_CNT_EN
  , output logic [CNT_W-1:0] mismatch_count
`endif
);
  localparam int IW = idx_w(NCH);
  state_t         state, state_nx;
  logic [W-1:0]   acc, step, sum;
  logic [IW-1:0]  idx;
  logic [NCH-1:0] valid;
  logic           last;
  assign RDY_start = state == IDLE;
  assign sum = acc + step;
  assign last = idx == IW'(NCH - 1);
  assign RDY_variable_result = valid;
  assign RDY_variable_check = valid;
  // DRAIN exits once no channel stays valid past this edge's accepted checks.
  always_comb begin
    state_nx = (state == IDLE && EN_start) ? RUN :
               (state == RUN && last) ? DRAIN :
               (state == DRAIN && ~|(valid & ~EN_variable_check)) ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      acc   <= '0;
      step  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (RDY_start && EN_start) begin
        acc  <= start_a;
        step <= start_b;
        idx  <= '0;
      end else if (state == RUN) begin
        acc <= sum;
        idx <= idx + 1'b1;
      end
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mk_chan_accum_lane #(.W(W)) u_lane (
      .clk      (CLK),
      .rst_n    (RST_N),
      .wr_en    (state == RUN && idx == IW'(k)),
      .wr_data  (sum),
      .c        (variable_result_c[k*W +: W]),
      .d        (variable_check_d[k*W +: W]),
      .en_check (EN_variable_check[k]),
      .result   (variable_result[k*W +: W]),
      .check    (variable_check[k*W +: W]),
      .rdy      (valid[k])
    );
  end
`ifdef MK_CHAN_ACCUM_MISMATCH_CNT_EN
  localparam int SW = $clog2(NCH + 1);
  localparam int AW = (CNT_W > SW ? CNT_W : SW) + 1;
  logic [SW-1:0] mm_sum;
  logic [AW-1:0] cnt_nx;
  // A nonzero check value on an accepted check is exactly a mismatch.
  always_comb begin
    mm_sum = '0;
    for (int k = 0; k < NCH; k++)
      mm_sum = mm_sum + SW'(EN_variable_check[k] & valid[k] & |variable_check[k*W +: W]);
    cnt_nx = AW'(mismatch_count) + AW'(mm_sum);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mismatch_count <= '0;
    else mismatch_count <= cnt_nx > AW'({CNT_W{1'b1}}) ? '1 : cnt_nx[CNT_W-1:0];
  end
`endif
endmodule
